lsu_bus_adapter: RTL
====================

Name: lsu_bus_adapter

Overview:
- Load/store unit sitting directly downstream of riscv_cpu's data-memory outputs (memop, memdata, mem_wen, mem_addr).
- Converts each single-cycle core request into a word-aligned valid/ready bus transaction with byte strobes.
- Waits for the bus response, then returns a sign- or zero-extended load result on mem_data.
- Raises a stall to the core while a transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT before the access is aborted with an error.
- CNT_W, 7: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- mem_valid  input  1  core requests an access this cycle
- mem_wen  input  1  1 = store, 0 = load
- memop  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- mem_addr  input  32  byte address
- memdata  input  32  store data, right-aligned
- mem_data  output  32  extended load result; valid when mem_done=1
- mem_done  output  1  one-cycle completion pulse
- mem_stall  output  1  core must hold its state
- mem_err  output  1  qualifies mem_done: timeout or illegal memop
- bus_req_valid  output  1  request valid
- bus_req_ready  input  1  request accepted
- bus_addr  output  32  word address ({addr[31:2], 2'b00})
- bus_wen  output  1  write request
- bus_wdata  output  32  lane-replicated store data
- bus_wstrb  output  4  byte enables; 0000 for loads
- bus_rvalid  input  1  response (read data, or write acknowledge)
- bus_rdata  input  32  read data

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, timeout counter 0.
- Reset mid-operation aborts the access immediately.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - When mem_valid=1, register wen, memop, addr, and the formatted wdata/wstrb.
  - Legal memop -> REQ. Illegal memop (011, 110, 111, or a store with memop[2]=1) -> DONE with the error flag set.
  - bus_rvalid is ignored in IDLE.
- REQ:
  - bus_req_valid=1; address, data and strobes are held stable until bus_req_ready=1, then -> WAIT.
  - No timeout applies in REQ.
- WAIT:
  - bus_req_valid=0; the counter increments every cycle.
  - bus_rvalid=1 -> capture bus_rdata and go to DONE.
  - If bus_rvalid and the timeout coincide, the response wins.
  - Counter reaching TIMEOUT_CYCLES -> DONE with the error flag set. Any late rvalid after this is dropped.
- DONE:
  - mem_done=1 for exactly one cycle; mem_err reflects the error flag.
  - mem_data is the extended load result; it is 0 for stores and for errors.
  - Next state is IDLE. A new mem_valid is sampled only in IDLE, so there are no back-to-back accepts from DONE.
- mem_stall = (IDLE & mem_valid) | REQ | WAIT. It is 0 in DONE.
- Minimum latency: valid at cycle 0 -> done at cycle 3, with ready and rvalid each asserted on first opportunity.
- Store formatting, with off = addr[1:0]:
  - SB: wdata = {4{memdata[7:0]}}, wstrb = 0001 << off.
  - SH: wdata = {2{memdata[15:0]}}, wstrb = 0011 << off.
  - SW: wdata = memdata, wstrb = 1111.
- Load extraction: shifted = bus_rdata >> (8*off); B/H sign-extend from bit 7/15, BU/HU zero-extend, W passes through.
- Misaligned halfword or word access without the optional feature: low address bits are used as given. SH at off=3 produces wstrb 1000, with the upper byte dropped. LW uses off 0.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - In IDLE, H/HU with addr[0]=1, or W with addr[1:0]!=0, goes straight to DONE with no bus transaction.
  - Adds output mem_misalign (1 bit), which is 1 together with mem_done and mem_err.
- Undefined: the mem_misalign port is absent and misaligned accesses behave as in Behaviour.

Decomposition:
- Shared package lsu_pkg contains:
  - memop localparams (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU);
  - FSM state encoding (2-bit);
  - strobe/extension helper functions.
- One combinational sub-module, lsu_align, contains the store replicate/strobe logic and the load shift/extend logic. The FSM and timeout counter stay in the top module.

Test Plan:
- LB addr 0x1003, bus_rdata 0x80FF1234, ready and rvalid immediate -> bus_addr 0x1000, wstrb 0000, mem_data 0xFFFFFF80, mem_done at cycle 3.
- LHU addr 0x2002, bus_rdata 0xBEEF0000 -> mem_data 0x0000BEEF, mem_err 0.
- SB addr 0x1001, memdata 0x000000AB, bus_req_ready held 0 for 4 cycles -> bus_addr 0x1000, wdata 0xABABABAB, wstrb 0010 stable throughout, mem_stall 1 until done, mem_data 0.
- LW with no rvalid, TIMEOUT_CYCLES=8 -> mem_done and mem_err after 8 WAIT cycles; rvalid in the following cycle is ignored and the FSM stays in IDLE.
- rst asserted in WAIT -> outputs 0 immediately; a stray rvalid is ignored; a new LW then completes normally.
- LSU_MISALIGN_TRAP_EN defined, LW addr 0x1002 -> no bus_req_valid, mem_done, mem_err and mem_misalign at cycle 1; memop 011 -> mem_err with mem_misalign 0.

Source files
------------

// File: rtl/lsu_bus_adapter_pkg.sv
// Shared types and helpers for the LSU bus adapter.
// Holds memop codes, FSM state encoding, and store/load formatting functions.
package lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Unsigned variants have no store form.
    function automatic logic lsu_illegal(
        input logic [2:0] op,
        input logic       wen
    );
        logic r;
        unique case (op)
            LSU_B, LSU_H, LSU_W: r = 1'b0;
            LSU_BU, LSU_HU:      r = wen;
            default:             r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic lsu_misaligned(
        input logic [2:0] op,
        input logic [1:0] off
    );
        logic r;
        unique case (op)
            LSU_H, LSU_HU: r = off[0];
            LSU_W:         r = (off != 2'b00);
            default:       r = 1'b0;
        endcase
        return r;
    endfunction

    // Upper lanes of a shifted halfword fall off the word.
    function automatic logic [3:0] lsu_strobe(
        input logic [2:0] op,
        input logic [1:0] off
    );
        logic [3:0] s;
        unique case (op[1:0])
            2'b00:   s = 4'b0001 << off;
            2'b01:   s = 4'b0011 << off;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] lsu_replicate(
        input logic [2:0]  op,
        input logic [31:0] data
    );
        logic [31:0] d;
        unique case (op[1:0])
            2'b00:   d = {4{data[7:0]}};
            2'b01:   d = {2{data[15:0]}};
            default: d = data;
        endcase
        return d;
    endfunction

    // Words ignore the low address bits.
    function automatic logic [31:0] lsu_extend(
        input logic [2:0]  op,
        input logic [1:0]  off,
        input logic [31:0] raw
    );
        logic [31:0] sh;
        logic [31:0] r;
        sh = raw >> {off, 3'b000};
        unique case (op)
            LSU_B:   r = {{24{sh[7]}}, sh[7:0]};
            LSU_H:   r = {{16{sh[15]}}, sh[15:0]};
            LSU_BU:  r = {24'd0, sh[7:0]};
            LSU_HU:  r = {16'd0, sh[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_bus_adapter_if.sv
// Word bus between the LSU adapter (master) and memory (slave).
// Request: valid/ready with addr, wen, wdata, wstrb. Response: rvalid, rdata.
interface lsu_bus_if;

    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_wen;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req_valid,
        input  bus_req_ready,
        output bus_addr,
        output bus_wen,
        output bus_wdata,
        output bus_wstrb,
        input  bus_rvalid,
        input  bus_rdata
    );

    modport slave (
        input  bus_req_valid,
        output bus_req_ready,
        input  bus_addr,
        input  bus_wen,
        input  bus_wdata,
        input  bus_wstrb,
        output bus_rvalid,
        output bus_rdata
    );

endinterface

// File: rtl/lsu_bus_adapter_align.sv
// Combinational lane formatting: store replicate/strobe, load shift/extend.
// Ports: st_* = core-side store operands, ld_* = captured load operands.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        st_wen,
    input  logic [2:0]  st_op,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [2:0]  ld_op,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    assign st_wdata = lsu_replicate(st_op, st_data);
    assign st_wstrb = st_wen ? lsu_strobe(st_op, st_off) : 4'b0000;
    assign ld_data  = lsu_extend(ld_op, ld_off, ld_raw);

endmodule

// File: rtl/lsu_bus_adapter.sv
// Load/store unit: turns a one-cycle core access into a bus transaction,
// stalls the core until the response, then returns the extended result.
// Ports: clk/rst; core side mem_*; bus side via lsu_bus_if.master.
// Optional LSU_MISALIGN_TRAP_EN: traps misaligned H/W, adds mem_misalign.
module lsu_bus_adapter
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_wen,
    input  logic [2:0]  memop,
    input  logic [31:0] mem_addr,
    input  logic [31:0] memdata,
    output logic [31:0] mem_data,
    output logic        mem_done,
    output logic        mem_stall,
    output logic        mem_err,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        mem_misalign,
`endif
    lsu_bus_if.master   bus
);

    lsu_state_e  state_q;
    lsu_state_e  state_d;

    logic        wen_q;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        err_q;
    logic [31:0] result_q;
    logic [CNT_W-1:0] cnt_q;

    logic        accept;
    logic        capture;
    logic        tmo_err;
    logic        req_bad;
    logic        tmo_hit;

    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] ld_data;

    lsu_align u_align (
        .st_wen   (mem_wen),
        .st_op    (memop),
        .st_off   (mem_addr[1:0]),
        .st_data  (memdata),
        .st_wdata (st_wdata),
        .st_wstrb (st_wstrb),
        .ld_op    (op_q),
        .ld_off   (addr_q[1:0]),
        .ld_raw   (bus.bus_rdata),
        .ld_data  (ld_data)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis;
    logic mis_q;

    // An illegal memop is reported as plain error, not misalignment.
    assign mis = !lsu_illegal(memop, mem_wen)
               && lsu_misaligned(memop, mem_addr[1:0]);
    assign req_bad = lsu_illegal(memop, mem_wen) | mis;
    assign mem_misalign = (state_q == ST_DONE) && mis_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else if (accept) begin
            mis_q <= mis;
        end
    end
`else
    assign req_bad = lsu_illegal(memop, mem_wen);
`endif

    // Counter holds the number of WAIT cycles already spent.
    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        accept            = 1'b0;
        capture           = 1'b0;
        tmo_err           = 1'b0;
        mem_stall         = 1'b0;
        mem_done          = 1'b0;
        bus.bus_req_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    accept    = 1'b1;
                    mem_stall = 1'b1;
                    state_d   = req_bad ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                mem_stall         = 1'b1;
                bus.bus_req_valid = 1'b1;
                if (bus.bus_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                mem_stall = 1'b1;
                // A response in the last allowed cycle beats the timeout.
                if (bus.bus_rvalid) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else if (tmo_hit) begin
                    tmo_err = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                mem_done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q    <= 1'b0;
            op_q     <= 3'b000;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            wstrb_q  <= 4'b0000;
            err_q    <= 1'b0;
            result_q <= 32'd0;
            cnt_q    <= '0;
        end else begin
            if (accept) begin
                wen_q    <= mem_wen;
                op_q     <= memop;
                addr_q   <= mem_addr;
                wdata_q  <= st_wdata;
                wstrb_q  <= st_wstrb;
                err_q    <= req_bad;
                result_q <= 32'd0;
            end
            if (capture) begin
                result_q <= wen_q ? 32'd0 : ld_data;
            end
            if (tmo_err) begin
                err_q <= 1'b1;
            end
            if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

    // Bus fields are driven only while a request is presented.
    always_comb begin
        bus.bus_addr  = 32'd0;
        bus.bus_wen   = 1'b0;
        bus.bus_wdata = 32'd0;
        bus.bus_wstrb = 4'b0000;
        if (state_q == ST_REQ) begin
            bus.bus_addr  = {addr_q[31:2], 2'b00};
            bus.bus_wen   = wen_q;
            bus.bus_wdata = wdata_q;
            bus.bus_wstrb = wstrb_q;
        end
    end

    assign mem_err  = (state_q == ST_DONE) && err_q;
    assign mem_data = (state_q == ST_DONE && !err_q) ? result_q : 32'd0;

endmodule
